// File: rtl/axi_burst_pkg.sv
// ----------------------------------------------------------------------------
// axi_burst_pkg
// Shared constants and types for the AXI4 burst write path.
//   - AXI encodings used by the writer (INCR burst, 4-byte beat size).
//   - Write response codes.
//   - Writer FSM state type.
//   - 4 KB boundary size that an AXI burst must never cross.
// ----------------------------------------------------------------------------
package axi_burst_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BOUNDARY_4K = 4096;
    localparam int BEAT_BYTES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/burst_len_calc.sv
// ----------------------------------------------------------------------------
// burst_len_calc
// Combinational burst length: min(remaining words, MAX_BURST, words left
// before the next 4 KB boundary).
//
// Ports
//   rem_i       in  CNT_W  words still to be written
//   page_off_i  in  10     word offset of the burst start inside its 4 KB page
//   len_o       out 9      beats in the next burst (1..MAX_BURST when rem_i>0)
// ----------------------------------------------------------------------------
module burst_len_calc #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic [CNT_W-1:0] rem_i,
    input  logic [9:0]       page_off_i,
    output logic [8:0]       len_o
);
    import axi_burst_pkg::*;

    // Common compare width: must hold the 4 KB distance (up to 1024 words).
    localparam int CW         = (CNT_W > 11) ? CNT_W : 11;
    localparam int PAGE_WORDS = BOUNDARY_4K / BEAT_BYTES;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] dist_w;
    logic [CW-1:0] min_w;

    always_comb begin
        rem_w  = CW'(rem_i);
        max_w  = CW'(MAX_BURST);
        dist_w = CW'(PAGE_WORDS) - CW'(page_off_i);
        min_w  = rem_w;
        if (max_w < min_w) begin
            min_w = max_w;
        end
        if (dist_w < min_w) begin
            min_w = dist_w;
        end
        // Result never exceeds MAX_BURST (<= 256), so 9 bits always suffice.
        len_o = 9'(min_w);
    end

endmodule

// File: rtl/axi_burst_writer.sv
// ----------------------------------------------------------------------------
// axi_burst_writer
// Drains 32-bit words from a first-word-fall-through FIFO and writes them to
// memory as AXI4 INCR bursts of at most MAX_BURST beats, never crossing a
// 4 KB boundary. One burst is outstanding at a time (AW, then W, then B).
//
// Build option
//   AXI_ERR_ABORT_EN  defined:   a non-OKAY BRESP ends the transfer after the
//                                current burst (remaining FIFO data untouched).
//                     undefined: error is recorded and the transfer completes.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               command strobe, ignored unless idle
//   base_addr           start byte address (bits [1:0] ignored)
//   total_words         number of words to write (0 = immediate done)
//   busy/done/error     status: busy level, done pulse, sticky error
//   fifo_read           FIFO pop, equal to the W handshake
//   fifo_data/empty     FIFO head word and empty flag
//   m_aw*/m_w*/m_b*     AXI4 write address, data and response channels
// ----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start; done pulse is emitted from here
// AW    | write address valid, held until m_awready
// W     | streaming len beats from the FIFO, wlast on the final one
// B     | waiting for the write response, then next burst or finish
// ----------------------------------------------------------------------------
module axi_burst_writer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  total_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);
    import axi_burst_pkg::*;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  rem_q,   rem_d;
    logic [7:0]        beat_q,  beat_d;
    logic              awvalid_q, awvalid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              error_q, error_d;

    logic [8:0]        len;
    logic [7:0]        len_m1;
    logic              bresp_bad;
    logic              last_burst;
    logic              w_hs;

    // addr and rem only change on the B handshake, so len is stable for the
    // whole AW/W/B sequence of a burst.
    burst_len_calc #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_len_calc (
        .rem_i      (rem_q),
        .page_off_i (addr_q[11:2]),
        .len_o      (len)
    );

    assign len_m1    = 8'(len - 9'd1);
    assign bresp_bad = (m_bresp != RESP_OKAY);

`ifdef AXI_ERR_ABORT_EN
    assign last_burst = (rem_q == CNT_W'(len)) || bresp_bad;
`else
    assign last_burst = (rem_q == CNT_W'(len));
`endif

    assign m_awaddr  = addr_q;
    assign m_awlen   = len_m1;
    assign m_awsize  = AXI_SIZE_4B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = awvalid_q;

    assign m_wvalid  = (state_q == ST_W) && !fifo_empty;
    assign m_wdata   = fifo_data;
    assign m_wstrb   = 4'hF;
    assign m_wlast   = (state_q == ST_W) && (beat_q == len_m1);
    assign w_hs      = m_wvalid && m_wready;
    assign fifo_read = w_hs;

    assign m_bready  = (state_q == ST_B);

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        awvalid_d = awvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    // Masking keeps every base_addr bit in use while forcing
                    // word alignment.
                    addr_d  = base_addr & ~ADDR_W'(3);
                    rem_d   = total_words;
                    if (total_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_AW;
                        busy_d    = 1'b1;
                        awvalid_d = 1'b1;
                    end
                end
            end

            ST_AW: begin
                if (awvalid_q && m_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_W;
                end
            end

            ST_W: begin
                if (w_hs) begin
                    beat_d = 8'(beat_q + 8'd1);
                    if (m_wlast) begin
                        state_d = ST_B;
                    end
                end
            end

            ST_B: begin
                if (m_bvalid) begin
                    if (bresp_bad) begin
                        error_d = 1'b1;
                    end
                    // Wraps modulo 2^ADDR_W by construction.
                    addr_d = addr_q + ADDR_W'({len, 2'b00});
                    rem_d  = rem_q - CNT_W'(len);
                    if (last_burst) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        awvalid_d = 1'b1;
                        state_d   = ST_AW;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// ----------------------------------------------------------------------------
// tb_axi_burst_writer
// Directed bench for axi_burst_writer. A FIFO model and an AXI slave model are
// stepped once per cycle: inputs change on the falling edge, outputs are
// sampled 1 ns later. Expected bursts and data words are queued when stimulus
// is set up and consumed as the DUT performs AW and W handshakes.
// ----------------------------------------------------------------------------
module tb_axi_burst_writer;
   import axi_burst_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] total_words;
   logic        busy, done, error, fifo_read;
   logic [31:0] fifo_data;
   logic        fifo_empty;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wlast, m_wvalid, m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;

   axi_burst_writer #(
      .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .total_words(total_words), .busy(busy), .done(done), .error(error),
      .fifo_read(fifo_read), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
      .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   aw_t         exp_aw[$];
   logic [31:0] exp_data[$];
   logic [31:0] src_q[$];
   logic [31:0] fifo_q[$];
   logic [1:0]  resp_q[$];

   int total = 0;
   int bad   = 0;

   bit          aw_open, b_pend, busy_model, err_model, done_due, aw_due;
   bit          prev_awpend;
   logic [31:0] prev_awaddr;
   logic [7:0]  prev_awlen;
   logic [1:0]  resp_cur;
   int          cur_len, cur_beat, pops;
   int          feed_period = 1, feed_cnt = 0, aw_pct = 100, w_pct = 100;
   bit          start_req;
   logic [31:0] base_req;
   logic [15:0] words_req;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic reset_model();
      exp_aw.delete(); exp_data.delete(); src_q.delete();
      fifo_q.delete(); resp_q.delete();
      aw_open = 0; b_pend = 0; busy_model = 0; err_model = 0;
      done_due = 0; aw_due = 0; prev_awpend = 0; cur_beat = 0; cur_len = 0;
   endtask

   task automatic sample();
      aw_t e;
      if (rst !== 1'b1) return;

      chk("done", done, done_due);
      chk("busy", busy, busy_model);
      chk("error", error, err_model);
      if (aw_due) chk("aw_latency", m_awvalid, 1'b1);
      done_due = 0;
      aw_due   = 0;

      chk("wvalid", m_wvalid, aw_open & !fifo_empty);
      chk("fifo_read", fifo_read, m_wvalid & m_wready);
      chk("wlast", m_wlast, aw_open && (cur_beat == cur_len - 1));
      chk("bready", m_bready, b_pend);

      if (prev_awpend) begin
         chk("awaddr_hold", m_awaddr, prev_awaddr);
         chk("awlen_hold", m_awlen, prev_awlen);
      end
      prev_awpend = m_awvalid & !m_awready;
      prev_awaddr = m_awaddr;
      prev_awlen  = m_awlen;

      if (m_awvalid && m_awready) begin
         chk("aw_expected", exp_aw.size() > 0, 1'b1);
         if (exp_aw.size() > 0) begin
            e = exp_aw.pop_front();
            chk("awaddr", m_awaddr, e.addr);
            chk("awlen", m_awlen, e.len);
         end else begin
            e.len = m_awlen;
         end
         chk("awsize", m_awsize, 3'b010);
         chk("awburst", m_awburst, 2'b01);
         cur_len  = int'(e.len) + 1;
         cur_beat = 0;
         aw_open  = 1;
      end

      if (m_wvalid && m_wready) begin
         chk("w_expected", exp_data.size() > 0, 1'b1);
         if (exp_data.size() > 0) chk("wdata", m_wdata, exp_data.pop_front());
         chk("wstrb", m_wstrb, 4'hF);
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pops++;
         cur_beat++;
         if (cur_beat >= cur_len) begin
            aw_open  = 0;
            b_pend   = 1;
            resp_cur = (resp_q.size() > 0) ? resp_q.pop_front() : RESP_OKAY;
         end
      end

      if (m_bvalid && m_bready) begin
         b_pend = 0;
         if (resp_cur != RESP_OKAY) err_model = 1;
         if (exp_aw.size() == 0) begin
            done_due   = 1;
            busy_model = 0;
         end
      end

      if (start && !busy_model) begin
         err_model = 0;
         if (total_words == 16'd0) begin
            done_due = 1;
         end else begin
            busy_model = 1;
            aw_due     = 1;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (src_q.size() > 0) begin
         feed_cnt++;
         if (feed_cnt >= feed_period) begin
            fifo_q.push_back(src_q.pop_front());
            feed_cnt = 0;
         end
      end
      fifo_empty  = (fifo_q.size() == 0);
      fifo_data   = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
      m_awready   = ($urandom_range(0, 99) < aw_pct);
      m_wready    = ($urandom_range(0, 99) < w_pct);
      m_bvalid    = b_pend;
      m_bresp     = b_pend ? resp_cur : RESP_OKAY;
      start       = start_req;
      base_addr   = base_req;
      total_words = words_req;
      start_req   = 0;
      #1;
      sample();
   endtask

   task automatic issue(input logic [31:0] a, input logic [15:0] w);
      start_req = 1;
      base_req  = a;
      words_req = w;
      tick();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy_model || done_due || aw_open || b_pend || exp_aw.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk("timeout", n >= budget, 1'b0);
      repeat (3) tick();
   endtask

   task automatic prefill(input int n, input logic [31:0] first);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(first + 32'(i));
         exp_data.push_back(first + 32'(i));
      end
   endtask

   task automatic load_src(input int n, input logic [31:0] first);
      for (int i = 0; i < n; i++) begin
         src_q.push_back(first + 32'(i));
         exp_data.push_back(first + 32'(i));
      end
   endtask

   task automatic push_bursts(input logic [31:0] a_in, input int w_in);
      logic [31:0] a;
      int          w, l, d;
      a = {a_in[31:2], 2'b00};
      w = w_in;
      while (w > 0) begin
         d = (4096 - int'(a[11:0])) / 4;
         l = (w < 16) ? w : 16;
         if (d < l) l = d;
         exp_aw.push_back('{a, 8'(l - 1)});
         a = a + 32'(l * 4);
         w = w - l;
      end
   endtask

   initial begin
      logic [31:0] rb;
      int          rw, n;

      rst = 1'b0; start = 1'b0; base_addr = '0; total_words = '0;
      fifo_data = '0; fifo_empty = 1'b1; m_awready = 1'b0; m_wready = 1'b0;
      m_bresp = RESP_OKAY; m_bvalid = 1'b0;
      start_req = 0; base_req = '0; words_req = '0;
      reset_model();
      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_awvalid", m_awvalid, 1'b0);
      chk("rst_wvalid", m_wvalid, 1'b0);
      chk("rst_wlast", m_wlast, 1'b0);
      chk("rst_fifo_read", fifo_read, 1'b0);
      chk("rst_bready", m_bready, 1'b0);
      chk("rst_awaddr", m_awaddr, 32'h0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();

      prefill(4, 32'd1);
      exp_aw.push_back('{32'h0000_1000, 8'd3});
      issue(32'h0000_1000, 16'd4);
      wait_idle(200);
      chk("t1_error", error, 1'b0);
      chk("t1_data_left", exp_data.size(), 0);

      pops = 0;
      prefill(40, 32'hA000);
      exp_aw.push_back('{32'h0000_0000, 8'd15});
      exp_aw.push_back('{32'h0000_0040, 8'd15});
      exp_aw.push_back('{32'h0000_0080, 8'd7});
      issue(32'h0, 16'd40);
      repeat (4) tick();
      issue(32'h0000_9000, 16'd3);
      wait_idle(500);
      chk("t2_pops", pops, 40);
      chk("t2_data_left", exp_data.size(), 0);

      prefill(4, 32'hB000);
      exp_aw.push_back('{32'h0000_0FF8, 8'd1});
      exp_aw.push_back('{32'h0000_1000, 8'd1});
      issue(32'h0000_0FF8, 16'd4);
      wait_idle(200);
      chk("t3_data_left", exp_data.size(), 0);

      feed_period = 3; aw_pct = 40; w_pct = 60;
      load_src(30, 32'hC000);
      exp_aw.push_back('{32'h0000_2FC0, 8'd15});
      exp_aw.push_back('{32'h0000_3000, 8'd13});
      issue(32'h0000_2FC3, 16'd30);
      wait_idle(3000);
      chk("t4_data_left", exp_data.size(), 0);
      feed_period = 1;

      prefill(8, 32'hD000);
      exp_aw.push_back('{32'hFFFF_FFF0, 8'd3});
      exp_aw.push_back('{32'h0000_0000, 8'd3});
      issue(32'hFFFF_FFF0, 16'd8);
      wait_idle(500);
      chk("wrap_data_left", exp_data.size(), 0);

      aw_pct = 70; w_pct = 70;
      rb = {$urandom_range(0, 255), 12'h000} + 32'($urandom_range(3900, 4095));
      rw = $urandom_range(1, 70);
      load_src(rw, 32'hE000);
      push_bursts(rb, rw);
      issue(rb, 16'(rw));
      wait_idle(3000);
      chk("rand_data_left", exp_data.size(), 0);
      aw_pct = 100; w_pct = 100;

      prefill(32, 32'h0100);
      resp_q.push_back(RESP_SLVERR);
      exp_aw.push_back('{32'h0000_4000, 8'd15});
`ifndef AXI_ERR_ABORT_EN
      exp_aw.push_back('{32'h0000_4040, 8'd15});
`endif
      issue(32'h0000_4000, 16'd32);
      wait_idle(500);
      chk("err_sticky", error, 1'b1);
`ifdef AXI_ERR_ABORT_EN
      chk("abort_fifo_left", fifo_q.size(), 16);
      chk("abort_data_left", exp_data.size(), 16);
      fifo_q.delete();
      exp_data.delete();
`else
      chk("err_fifo_left", fifo_q.size(), 0);
      chk("err_data_left", exp_data.size(), 0);
`endif

      issue(32'h0000_0100, 16'd0);
      wait_idle(50);
      chk("zero_err_clear", error, 1'b0);

      prefill(8, 32'h0500);
      exp_aw.push_back('{32'h0000_5000, 8'd7});
      cur_beat = 0;
      issue(32'h0000_5000, 16'd8);
      n = 0;
      while (!(aw_open && cur_beat >= 2) && n < 100) begin
         tick();
         n++;
      end
      chk("rst_wait", n >= 100, 1'b0);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_error", error, 1'b0);
      chk("arst_awvalid", m_awvalid, 1'b0);
      chk("arst_wvalid", m_wvalid, 1'b0);
      chk("arst_wlast", m_wlast, 1'b0);
      chk("arst_fifo_read", fifo_read, 1'b0);
      chk("arst_bready", m_bready, 1'b0);
      reset_model();
      tick(); tick();
      rst = 1'b1;
      tick();

      prefill(5, 32'h0600);
      exp_aw.push_back('{32'h0000_6000, 8'd4});
      issue(32'h0000_6000, 16'd5);
      wait_idle(200);
      chk("post_rst_data_left", exp_data.size(), 0);
      chk("post_rst_error", error, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
